// File: rtl/debug_pkg.sv
// Debug-protocol definitions shared by the serial decoder and the debug controller:
// function codes, default reply bytes and the per-command frame/reply length lookup.
package debug_pkg;

    typedef enum logic [3:0] {
        FN_PAUSE     = 4'h1,
        FN_RESUME    = 4'h2,
        FN_STEP      = 4'h3,
        FN_RESET     = 4'h4,
        FN_STATUS    = 4'h5,
        FN_RD_REG    = 4'h6,
        FN_RD_WORD   = 4'h7,
        FN_RD_BYTE   = 4'h8,
        FN_SET_BP    = 4'h9,
        FN_CLR_BP    = 4'hA,
        FN_WR_REG    = 4'hB,
        FN_WR_WORD   = 4'hC,
        FN_WR_BYTE   = 4'hD
    } fn_e;

    localparam logic [7:0] ACK_DEFAULT = 8'hA5;
    localparam logic [7:0] NAK_DEFAULT = 8'hEE;

    function automatic logic cmd_byte_ok(input logic [7:0] b);
        return (b[7:4] == 4'h0) && (b[3:0] >= FN_PAUSE) && (b[3:0] <= FN_WR_BYTE);
    endfunction

    function automatic logic [2:0] addr_bytes(input logic [3:0] c);
        return (c >= FN_RD_REG && c <= FN_WR_BYTE) ? 3'd4 : 3'd0;
    endfunction

    function automatic logic [2:0] data_bytes(input logic [3:0] c);
        return (c >= FN_WR_REG && c <= FN_WR_BYTE) ? 3'd4 : 3'd0;
    endfunction

    // Reads return the full 32-bit word; every other accepted command gets one ACK byte.
    function automatic logic [2:0] reply_bytes(input logic [3:0] c);
        return (c >= FN_STATUS && c <= FN_RD_BYTE) ? 3'd4 : 3'd1;
    endfunction

endpackage

// File: rtl/serial_decoder_if.sv
// Signal bundle between the serial decoder and its environment (UART rx/tx and debug controller).
interface serial_decoder_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        out_valid;
    logic        ctrlr_busy;
    logic [31:0] rd_data;
    logic        error;

    modport slave (
        input  rx_data, rx_valid, tx_busy, ctrlr_busy, rd_data,
        output tx_data, tx_start, cmd, addr, wr_data, out_valid, error
    );

    modport master (
        output rx_data, rx_valid, tx_busy, ctrlr_busy, rd_data,
        input  tx_data, tx_start, cmd, addr, wr_data, out_valid, error
    );
endinterface

// File: rtl/serial_decoder_reply_serializer.sv
// Loads a reply of 1..4 bytes and hands it to the UART transmitter MSB first,
// never starting on two consecutive cycles so the transmitter has time to raise busy.
module reply_serializer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] load_word_i,
    input  logic [2:0]  load_len_i,
    input  logic        tx_busy_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_start_o,
    output logic        last_o
);
    logic [31:0] shift_q;
    logic [2:0]  left_q;
    logic [7:0]  tx_data_q;
    logic        tx_start_q;
    logic        send;

    assign send   = (left_q != 3'd0) && !tx_busy_i && !tx_start_q;
    assign last_o = send && (left_q == 3'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q    <= 32'h0;
            left_q     <= 3'd0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
        end else begin
            tx_start_q <= send;
            if (load_i) begin
                shift_q <= load_word_i;
                left_q  <= load_len_i;
            end else if (send) begin
                tx_data_q <= shift_q[31:24];
                shift_q   <= {shift_q[23:0], 8'h00};
                left_q    <= left_q - 3'd1;
            end
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_start_o = tx_start_q;
endmodule

// File: rtl/serial_decoder.sv
// Debug-link frame decoder: parses command/address/data bytes from the UART, issues one
// command to the debug controller and returns the read word, ACK or NAK.
//
// state   | meaning
// S_IDLE  | waiting for a command byte
// S_ADDR  | collecting 4 address bytes, MSB first
// S_DATA  | collecting 4 write-data bytes, MSB first
// S_ISSUE | frame complete, waiting for the controller to go idle
// S_WAIT  | command issued, waiting for the controller to finish
// S_REPLY | reply bytes being handed to the UART
module serial_decoder
    import debug_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  ACK_BYTE       = ACK_DEFAULT,
    parameter logic [7:0]  NAK_BYTE       = NAK_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    serial_decoder_if.slave bus
);
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES) > 20) ? $clog2(TIMEOUT_CYCLES) : 20;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_ISSUE, S_WAIT, S_REPLY} state_e;

    state_e           state_q;
    logic [3:0]       cmd_q;
    logic [31:0]      addr_q;
    logic [31:0]      wr_data_q;
    logic [31:0]      rd_q;
    logic             out_valid_q;
    logic             error_q;
    logic             ld_q;
    logic [2:0]       ld_len_q;
    logic [7:0]       ld_byte_q;
    logic [1:0]       byte_cnt_q;
    logic [TMO_W-1:0] tmo_q;

    logic [3:0]  rx_cmd;
    logic [31:0] ser_word;
    logic        ser_last;
    logic [7:0]  ser_tx_data;
    logic        ser_tx_start;

    assign rx_cmd   = bus.rx_data[3:0];
    assign ser_word = (ld_len_q == 3'd4) ? rd_q : {ld_byte_q, 24'h0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_q       <= 4'h0;
            addr_q      <= 32'h0;
            wr_data_q   <= 32'h0;
            rd_q        <= 32'h0;
            out_valid_q <= 1'b0;
            error_q     <= 1'b0;
            ld_q        <= 1'b0;
            ld_len_q    <= 3'd0;
            ld_byte_q   <= 8'h00;
            byte_cnt_q  <= 2'd0;
            tmo_q       <= '0;
        end else begin
            out_valid_q <= 1'b0;
            error_q     <= 1'b0;
            ld_q        <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.rx_valid) begin
                        if (!cmd_byte_ok(bus.rx_data)) begin
                            error_q   <= 1'b1;
                            ld_q      <= 1'b1;
                            ld_len_q  <= 3'd1;
                            ld_byte_q <= NAK_BYTE;
                            state_q   <= S_REPLY;
                        end else begin
                            cmd_q      <= rx_cmd;
                            addr_q     <= 32'h0;
                            wr_data_q  <= 32'h0;
                            byte_cnt_q <= 2'd0;
                            tmo_q      <= '0;
                            // Skip S_ISSUE when the controller is already free: 1-cycle latency.
                            if (addr_bytes(rx_cmd) != 3'd0) begin
                                state_q <= S_ADDR;
                            end else if (!bus.ctrlr_busy) begin
                                out_valid_q <= 1'b1;
                                state_q     <= S_WAIT;
                            end else begin
                                state_q <= S_ISSUE;
                            end
                        end
                    end
                end
                S_ADDR, S_DATA: begin
                    if (bus.rx_valid) begin
                        tmo_q      <= '0;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (state_q == S_ADDR) addr_q    <= {addr_q[23:0], bus.rx_data};
                        else                   wr_data_q <= {wr_data_q[23:0], bus.rx_data};
                        if (byte_cnt_q == 2'd3) begin
                            if (state_q == S_ADDR && data_bytes(cmd_q) != 3'd0) begin
                                state_q <= S_DATA;
                            end else if (!bus.ctrlr_busy) begin
                                out_valid_q <= 1'b1;
                                state_q     <= S_WAIT;
                            end else begin
                                state_q <= S_ISSUE;
                            end
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        error_q    <= 1'b1;
                        tmo_q      <= '0;
                        byte_cnt_q <= 2'd0;
                        state_q    <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                S_ISSUE: begin
                    if (bus.rx_valid) error_q <= 1'b1;
                    if (!bus.ctrlr_busy) begin
                        out_valid_q <= 1'b1;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.rx_valid) error_q <= 1'b1;
                    // Busy is only meaningful from the cycle after the out_valid strobe.
                    if (!out_valid_q && !bus.ctrlr_busy) begin
                        rd_q      <= bus.rd_data;
                        ld_q      <= 1'b1;
                        ld_len_q  <= reply_bytes(cmd_q);
                        ld_byte_q <= ACK_BYTE;
                        state_q   <= S_REPLY;
                    end
                end
                S_REPLY: begin
                    if (bus.rx_valid) error_q <= 1'b1;
                    if (ser_last) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    reply_serializer u_reply (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ld_q),
        .load_word_i(ser_word),
        .load_len_i (ld_len_q),
        .tx_busy_i  (bus.tx_busy),
        .tx_data_o  (ser_tx_data),
        .tx_start_o (ser_tx_start),
        .last_o     (ser_last)
    );

    assign bus.tx_data   = ser_tx_data;
    assign bus.tx_start  = ser_tx_start;
    assign bus.cmd       = cmd_q;
    assign bus.addr      = addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.error     = error_q;
endmodule
